// File: rtl/mod6_pkg.sv
// mod6_pkg: shared digit types and helpers for the cascaded countdown timer.
// Provides digit_t (also used by the mod-10 stages), MOD6_MAX and MOD6_W.
package mod6_pkg;

    localparam int MOD6_W = 4;

    typedef logic [MOD6_W-1:0] digit_t;

    localparam digit_t MOD6_MAX = 4'd5;

    // Clamp an arbitrary BCD nibble into the legal 0..5 range.
    function automatic digit_t mod6_sat(input digit_t d);
        return (d > MOD6_MAX) ? MOD6_MAX : d;
    endfunction

    // One step down with wrap 0 -> 5.
    function automatic digit_t mod6_dec(input digit_t d);
        return (d == 4'd0) ? MOD6_MAX : d - 4'd1;
    endfunction

endpackage

// File: rtl/mod6.sv
// mod6: modulo-6 down-counter for the tens-of-seconds digit.
// Ports: clock, clrn (async clear, active-low), data/loadn (sync load,
// active-low, saturating at 5), enable (count / borrow-in),
// tens (digit 0..5), zero (tens == 0), tc (borrow-out = enable & zero).
module mod6
    import mod6_pkg::*;
(
    input  logic       clock,
    input  logic       clrn,
    input  logic [3:0] data,
    input  logic       loadn,
    input  logic       enable,
    output logic [3:0] tens,
    output logic       tc,
    output logic       zero
);

    digit_t count;

    // Priority: clear, then load, then count, else hold.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            count <= '0;
        end else if (!loadn) begin
            count <= mod6_sat(data);
        end else if (enable) begin
            count <= mod6_dec(count);
        end
    end

    assign tens = count;
    assign zero = (count == 4'd0);
    // Borrow-out fires in the cycle whose enabled edge wraps 0 -> 5.
    assign tc   = enable & zero;

    a_range : assert property (@(posedge clock) count <= MOD6_MAX)
        else $error("tens out of range: %0d", count);

    a_tc_zero : assert property (@(posedge clock) tc |-> zero)
        else $error("tc asserted while tens nonzero");

endmodule

// File: tb/tb_mod6.sv
// tb_mod6: self-checking bench for mod6 with a behavioural digit model.
// Scenario tasks run in sequence; one summary line at the end.
module tb_mod6;

    logic       clock = 1'b0;
    logic       clrn;
    logic [3:0] data;
    logic       loadn;
    logic       enable;
    logic [3:0] tens;
    logic       tc;
    logic       zero;

    int checks = 0;
    int errors = 0;
    int model  = 0;

    mod6 dut (
        .clock  (clock),
        .clrn   (clrn),
        .data   (data),
        .loadn  (loadn),
        .enable (enable),
        .tens   (tens),
        .tc     (tc),
        .zero   (zero)
    );

    always #5 clock = ~clock;

    // Apply inputs on the falling edge; a low clrn clears the model at once.
    task automatic drive(input logic c, input logic l, input logic e,
                         input logic [3:0] d);
        @(negedge clock);
        clrn   = c;
        loadn  = l;
        enable = e;
        data   = d;
        if (!c) model = 0;
    endtask

    // Advance one rising edge and update the model from the rules.
    task automatic tick();
        @(posedge clock);
        if (!clrn) model = 0;
        else if (!loadn) model = (data > 4'd5) ? 5 : int'(data);
        else if (enable) model = (model + 5) % 6;
        #1;
    endtask

    task automatic test_reset();
        clrn = 1'b0; loadn = 1'b1; enable = 1'b1; data = 4'd0;
        model = 0;
        #1;
        checks++;
        if (tens !== 4'd0 || zero !== 1'b1 || tc !== 1'b1) begin
            errors++;
            $display("FAIL reset_init tens=%0d zero=%b tc=%b want 0 1 1",
                     tens, zero, tc);
        end
        drive(1'b1, 1'b0, 1'b0, 4'd3);
        tick();
        checks++;
        if (tens !== 4'd3) begin
            errors++;
            $display("FAIL reset_preload tens=%0d want 3", tens);
        end
        // Clear mid-cycle, away from any edge.
        #2;
        clrn = 1'b0; enable = 1'b1; loadn = 1'b1; model = 0;
        #1;
        checks++;
        if (tens !== 4'd0 || zero !== 1'b1 || tc !== 1'b1) begin
            errors++;
            $display("FAIL reset_async tens=%0d zero=%b tc=%b want 0 1 1",
                     tens, zero, tc);
        end
        drive(1'b1, 1'b1, 1'b1, 4'd0);
        tick();
        checks++;
        if (tens !== 4'd5) begin
            errors++;
            $display("FAIL reset_resume tens=%0d want 5", tens);
        end
    endtask

    task automatic test_load();
        drive(1'b1, 1'b0, 1'b0, 4'd1);
        tick();
        checks++;
        if (tens !== 4'd1 || zero !== 1'b0) begin
            errors++;
            $display("FAIL load_1 tens=%0d zero=%b want 1 0", tens, zero);
        end
        drive(1'b1, 1'b0, 1'b0, 4'd4);
        tick();
        checks++;
        if (tens !== 4'd4) begin
            errors++;
            $display("FAIL load_4 tens=%0d want 4", tens);
        end
    endtask

    task automatic test_count_wrap();
        int exp_seq[12] = '{3, 2, 1, 0, 5, 4, 3, 2, 1, 0, 5, 4};
        drive(1'b1, 1'b1, 1'b1, 4'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (tens !== 4'(exp_seq[i]) ||
                zero !== (exp_seq[i] == 0) ||
                tc !== (exp_seq[i] == 0)) begin
                errors++;
                $display("FAIL count_%0d tens=%0d zero=%b tc=%b want %0d",
                         i, tens, zero, tc, exp_seq[i]);
            end
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 1'b0, 1'b0, 4'd2);
        tick();
        drive(1'b1, 1'b1, 1'b0, 4'd7);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (tens !== 4'd2 || tc !== 1'b0 || zero !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d tens=%0d tc=%b zero=%b want 2 0 0",
                         i, tens, tc, zero);
            end
        end
    endtask

    task automatic test_priority();
        drive(1'b1, 1'b0, 1'b0, 4'd9);
        tick();
        checks++;
        if (tens !== 4'd5) begin
            errors++;
            $display("FAIL sat_9 tens=%0d want 5", tens);
        end
        drive(1'b1, 1'b0, 1'b1, 4'd15);
        tick();
        checks++;
        if (tens !== 4'd5) begin
            errors++;
            $display("FAIL sat_15 tens=%0d want 5", tens);
        end
        drive(1'b1, 1'b0, 1'b1, 4'd2);
        tick();
        checks++;
        if (tens !== 4'd2) begin
            errors++;
            $display("FAIL load_over_count tens=%0d want 2", tens);
        end
        // Load from zero with enable high: tc reflects current digit.
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 4'd3);
        #1;
        checks++;
        if (tc !== 1'b1) begin
            errors++;
            $display("FAIL tc_during_load tc=%b want 1", tc);
        end
        tick();
        checks++;
        if (tens !== 4'd3 || tc !== 1'b0) begin
            errors++;
            $display("FAIL load_from_zero tens=%0d tc=%b want 3 0", tens, tc);
        end
        drive(1'b0, 1'b0, 1'b1, 4'd4);
        tick();
        checks++;
        if (tens !== 4'd0) begin
            errors++;
            $display("FAIL clear_over_load tens=%0d want 0", tens);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 15) != 0),
                  ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)));
            #1;
            checks++;
            if (tens !== 4'(model) || zero !== (model == 0) ||
                tc !== (enable && model == 0)) begin
                errors++;
                $display("FAIL rand_pre_%0d tens=%0d zero=%b tc=%b want %0d",
                         i, tens, zero, tc, model);
            end
            tick();
            checks++;
            if (tens !== 4'(model)) begin
                errors++;
                $display("FAIL rand_post_%0d tens=%0d want %0d",
                         i, tens, model);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_count_wrap();
        test_hold();
        test_priority();
        drive(1'b1, 1'b1, 1'b0, 4'd0);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
